// File: rtl/step_input_ctrl_if.sv
// Board-side bundle for step_input_ctrl: raw BTN/SW in, conditioned levels, strobes and CPU controls out.
interface step_input_ctrl_if;
    logic [3:0]  BTN;
    logic [3:0]  SW;
    logic [3:0]  btn_db;
    logic [3:0]  sw_db;
    logic [3:0]  btn_rise;
    logic        cpu_rst;
    logic        cpu_en;
    logic        run_mode;
    logic [15:0] step_count;

    modport master (
        output BTN, SW,
        input  btn_db, sw_db, btn_rise, cpu_rst, cpu_en, run_mode, step_count
    );

    modport slave (
        input  BTN, SW,
        output btn_db, sw_db, btn_rise, cpu_rst, cpu_en, run_mode, step_count
    );
endinterface

// File: rtl/step_input_ctrl.sv
// Input front end: 2-flop sync + debounce of BTN/SW, rise strobes, CPU reset, step/run clock-enable.
// Latency: raw change to debounced level at edge 2+DEBOUNCE_CYCLES; cpu_en one edge after btn_rise[2].
// Backpressure: none; all outputs are free-running levels or one-cycle strobes.
module step_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16,
    parameter int RUN_DIV         = 25000000,
    parameter int DIV_W           = 25
) (
    input  logic             CCLK,
    input  logic             rst,
    step_input_ctrl_if.slave io
);
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

    logic [7:0]       raw;
    logic [7:0]       s1;
    logic [7:0]       s2;
    logic [7:0]       stable;
    logic [CNT_W-1:0] db_cnt [8];
    logic [3:0]       btn_prev;
    logic [3:0]       btn_rise;
    logic             run_mode;
    logic             run_prev;
    logic             mode_chg;
    logic             hold;
    logic [DIV_W-1:0] div;
    logic             cpu_rst_q;
    logic             cpu_en_q;
    logic [15:0]      step_cnt_q;

    assign raw = {io.SW, io.BTN};

    always_ff @(posedge CCLK or posedge rst) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // Any sample matching the stable level restarts that bit's count.
    always_ff @(posedge CCLK or posedge rst) begin
        if (rst) begin
            stable <= '0;
            for (int i = 0; i < 8; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (s2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    stable[i] <= s2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign btn_rise = stable[3:0] & ~btn_prev;
    assign run_mode = stable[4];
    assign mode_chg = run_mode ^ run_prev;
    // A debounced BTN[3] already blocks cpu_en so a simultaneous step press cannot slip through.
    assign hold     = cpu_rst_q | stable[3];

    always_ff @(posedge CCLK or posedge rst) begin
        if (rst) begin
            btn_prev   <= '0;
            run_prev   <= 1'b0;
            cpu_rst_q  <= 1'b1;
            cpu_en_q   <= 1'b0;
            div        <= '0;
            step_cnt_q <= '0;
        end else begin
            btn_prev  <= stable[3:0];
            run_prev  <= run_mode;
            cpu_rst_q <= stable[3];

            if (hold || mode_chg) begin
                div      <= '0;
                cpu_en_q <= 1'b0;
            end else if (run_mode) begin
                if (div == DIV_LAST) begin
                    div      <= '0;
                    cpu_en_q <= 1'b1;
                end else begin
                    div      <= div + DIV_W'(1);
                    cpu_en_q <= 1'b0;
                end
            end else begin
                div      <= '0;
                cpu_en_q <= btn_rise[2];
            end

            if (cpu_rst_q) begin
                step_cnt_q <= '0;
            end else if (cpu_en_q) begin
                step_cnt_q <= step_cnt_q + 16'd1;
            end
        end
    end

    assign io.btn_db     = stable[3:0];
    assign io.sw_db      = stable[7:4];
    assign io.btn_rise   = btn_rise;
    assign io.cpu_rst    = cpu_rst_q;
    assign io.cpu_en     = cpu_en_q;
    assign io.run_mode   = run_mode;
    assign io.step_count = step_cnt_q;
endmodule
